// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder for a pipeline MEM stage.
// Accepts one load/store at a time, stalls the pipe, and pulses Ready (and Error on rejects).
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Stall,
    output logic        Error
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH];

    logic              req;
    logic              acc_err;
    logic [IdxW-1:0]   acc_idx;

    assign req     = MemRead | MemWrite;
    assign acc_idx = Address[IdxW+1:2];
    assign acc_err = (MemRead && MemWrite) || (Address[1:0] != 2'b00) ||
                     ({2'b00, Address[31:2]} >= DEPTH);

    assign Stall = (state_q == StBusy) || ((state_q == StIdle) && req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            Ready    <= 1'b0;
            Error    <= 1'b0;
            ReadData <= '0;
        end else begin
            Ready <= 1'b0;
            Error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        idx_q   <= acc_idx;
                        wdata_q <= WriteData;
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        err_q   <= acc_err;
                        cnt_q   <= 4'(LATENCY - 1);
                        // Single-cycle latency completes straight from the live request.
                        if (LATENCY == 1) begin
                            state_q <= StDone;
                            Ready   <= 1'b1;
                            Error   <= acc_err;
                            if (acc_err) begin
                                ReadData <= '0;
                            end else if (MemRead) begin
                                ReadData <= mem[acc_idx];
                            end
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StDone;
                        Ready   <= 1'b1;
                        Error   <= err_q;
                        if (err_q) begin
                            ReadData <= '0;
                        end else if (rd_q) begin
                            ReadData <= mem[idx_q];
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stores commit on the edge leaving DONE, so a reset before then drops them.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == StDone) && wr_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked against a
// transaction-level memory model with directed and randomized accesses.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        mrd   [3];
    logic        mwr   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        stall [3];
    logic        err   [3];

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_m  [3][256];
    logic [31:0] last_m [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (256),
            .LATENCY (g == 0 ? 2 : (g == 1 ? 1 : 15))
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .MemRead   (mrd[g]),
            .MemWrite  (mwr[g]),
            .Address   (addr[g]),
            .WriteData (wdata[g]),
            .ReadData  (rdata[g]),
            .Ready     (rdy[g]),
            .Stall     (stall[g]),
            .Error     (err[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    // Expected completion of one access; updates the model memory and held ReadData.
    task automatic model_apply(input int k, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] exp_d, output logic exp_e);
        exp_e = (rd && wr) || (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        if (exp_e) exp_d = 32'h0;
        else if (rd) exp_d = mem_m[k][a[9:2]];
        else exp_d = last_m[k];
        if (!exp_e && wr) mem_m[k][a[9:2]] = wd;
        last_m[k] = exp_d;
    endtask

    // Drives one request from IDLE and records what the DUT did until Ready (or timeout).
    task automatic run_access(input int k, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic keep, input logic [31:0] alt_a,
                              input logic [31:0] alt_wd,
                              output int rc, output int sc, output logic [31:0] rdv,
                              output logic ev, output logic ds);
        rc = -1; sc = 0; rdv = 'x; ev = 'x; ds = 'x;
        @(negedge clk);
        mrd[k] = rd; mwr[k] = wr; addr[k] = a; wdata[k] = wd;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (rdy[k] === 1'b1) begin
                rc = c; rdv = rdata[k]; ev = err[k]; ds = stall[k];
                break;
            end
            if (stall[k] === 1'b1) sc++;
            @(negedge clk);
            if (c == 0) begin
                mrd[k] = keep ? rd : 1'b0;
                mwr[k] = keep ? wr : 1'b0;
                addr[k] = alt_a; wdata[k] = alt_wd;
            end
        end
        mrd[k] = 1'b0; mwr[k] = 1'b0;
    endtask

    task automatic test_reset();
        int pulses [3];
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; mrd[k] = 1'b1; mwr[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            mrd[k] = 1'b0;
            #1;
            n_checks++;
            if (rdy[k] !== 1'b0) $display("FAIL reset_ready k=%0d got %b want 0", k, rdy[k]);
            else n_pass++;
            n_checks++;
            if (err[k] !== 1'b0) $display("FAIL reset_error k=%0d got %b want 0", k, err[k]);
            else n_pass++;
            n_checks++;
            if (rdata[k] !== 32'h0) $display("FAIL reset_rdata k=%0d got %h want 0", k, rdata[k]);
            else n_pass++;
            n_checks++;
            if (stall[k] !== 1'b0) $display("FAIL reset_stall k=%0d got %b want 0", k, stall[k]);
            else n_pass++;
            rst[k] = 1'b0; last_m[k] = 32'h0; pulses[k] = 0;
        end
        // The request held across the reset edges must not have been accepted.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 3; k++) if (rdy[k] === 1'b1) pulses[k]++;
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (pulses[k] != 0) $display("FAIL reset_priority k=%0d got %0d pulses want 0", k, pulses[k]);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        int rc, sc; logic [31:0] rdv, ed; logic ev, ds, ee;
        model_apply(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ed, ee);
        run_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h4, 32'h5, rc, sc, rdv, ev, ds);
        n_checks++;
        if (rc != 2) $display("FAIL wr_ready_cycle got %0d want 2", rc); else n_pass++;
        n_checks++;
        if (sc != 2) $display("FAIL wr_stall_cycles got %0d want 2", sc); else n_pass++;
        n_checks++;
        if (rdv !== ed) $display("FAIL wr_rdata_held got %h want %h", rdv, ed); else n_pass++;
        model_apply(0, 1'b1, 1'b0, 32'h10, 32'h0, ed, ee);
        run_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h14, 32'h0, rc, sc, rdv, ev, ds);
        n_checks++;
        if (rc != 2) $display("FAIL rd_ready_cycle got %0d want 2", rc); else n_pass++;
        n_checks++;
        if (sc != 2) $display("FAIL rd_stall_cycles got %0d want 2", sc); else n_pass++;
        n_checks++;
        if (rdv !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rdv); else n_pass++;
        n_checks++;
        if (ev !== 1'b0 || ds !== 1'b0)
            $display("FAIL rd_err_stall got err=%b stall=%b want 0/0", ev, ds);
        else n_pass++;
    endtask

    task automatic test_latency_sweep();
        int rc, sc; logic [31:0] rdv, ed, v; logic ev, ds, ee;
        for (int k = 1; k < 3; k++) begin
            v = $urandom;
            model_apply(k, 1'b0, 1'b1, 32'h0, v, ed, ee);
            run_access(k, 1'b0, 1'b1, 32'h0, v, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
            model_apply(k, 1'b1, 1'b0, 32'h0, 32'h0, ed, ee);
            run_access(k, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
            n_checks++;
            if (rc != lat_of(k)) $display("FAIL sweep_ready k=%0d got %0d want %0d", k, rc, lat_of(k));
            else n_pass++;
            n_checks++;
            if (sc != lat_of(k)) $display("FAIL sweep_stall k=%0d got %0d want %0d", k, sc, lat_of(k));
            else n_pass++;
            n_checks++;
            if (rdv !== ed) $display("FAIL sweep_rdata k=%0d got %h want %h", k, rdv, ed);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        int rc, sc; logic [31:0] rdv, ed, fa; logic ev, ds, ee;
        logic        t_rd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        t_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] t_a  [4] = '{32'h12, 32'h12, 32'h400, 32'h10};
        logic [31:0] t_fa [4] = '{32'h10, 32'h10, 32'h0, 32'h10};
        model_apply(0, 1'b0, 1'b1, 32'h0, 32'hA5A5_0001, ed, ee);
        run_access(0, 1'b0, 1'b1, 32'h0, 32'hA5A5_0001, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
        for (int i = 0; i < 4; i++) begin
            model_apply(0, t_rd[i], t_wr[i], t_a[i], 32'hBAD0_0000 + i, ed, ee);
            run_access(0, t_rd[i], t_wr[i], t_a[i], 32'hBAD0_0000 + i, 1'b0, 32'h0, 32'h0,
                       rc, sc, rdv, ev, ds);
            n_checks++;
            if (ev !== 1'b1 || rc != 2)
                $display("FAIL err_flag case=%0d got err=%b ready@%0d want 1 @2", i, ev, rc);
            else n_pass++;
            n_checks++;
            if (rdv !== 32'h0) $display("FAIL err_rdata case=%0d got %h want 0", i, rdv);
            else n_pass++;
            fa = t_fa[i];
            model_apply(0, 1'b1, 1'b0, fa, 32'h0, ed, ee);
            run_access(0, 1'b1, 1'b0, fa, 32'h0, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
            n_checks++;
            if (rdv !== ed || ev !== 1'b0)
                $display("FAIL err_mem_intact case=%0d got %h err=%b want %h err=0", i, rdv, ev, ed);
            else n_pass++;
        end
    endtask

    task automatic test_input_hold();
        int rc, sc; logic [31:0] rdv, ed, va, vb; logic ev, ds, ee;
        va = $urandom; vb = ~va;
        model_apply(0, 1'b0, 1'b1, 32'h8, va, ed, ee);
        run_access(0, 1'b0, 1'b1, 32'h8, va, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
        model_apply(0, 1'b0, 1'b1, 32'hC, vb, ed, ee);
        run_access(0, 1'b0, 1'b1, 32'hC, vb, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
        model_apply(0, 1'b1, 1'b0, 32'h8, 32'h0, ed, ee);
        run_access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'hC, 32'h0, rc, sc, rdv, ev, ds);
        n_checks++;
        if (rdv !== va || rc != 2) $display("FAIL hold_addr got %h @%0d want %h @2", rdv, rc, va);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int rc, sc, pulses; logic [31:0] rdv, ed; logic ev, ds, ee;
        for (int k = 0; k < 3; k += 2) begin
            model_apply(k, 1'b0, 1'b1, 32'h20, 32'h0, ed, ee);
            run_access(k, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
            @(negedge clk);
            mwr[k] = 1'b1; addr[k] = 32'h20; wdata[k] = 32'h12345678;
            @(negedge clk);
            mwr[k] = 1'b0; rst[k] = 1'b1;
            @(negedge clk);
            rst[k] = 1'b0; last_m[k] = 32'h0; pulses = 0;
            #1;
            n_checks++;
            if (rdata[k] !== 32'h0) $display("FAIL midrst_rdata k=%0d got %h want 0", k, rdata[k]);
            else n_pass++;
            repeat (lat_of(k) + 4) begin
                @(negedge clk); #1;
                if (rdy[k] === 1'b1 || err[k] === 1'b1) pulses++;
            end
            n_checks++;
            if (pulses != 0) $display("FAIL midrst_no_ready k=%0d got %0d pulses want 0", k, pulses);
            else n_pass++;
            model_apply(k, 1'b1, 1'b0, 32'h20, 32'h0, ed, ee);
            run_access(k, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
            n_checks++;
            if (rdv !== 32'h0) $display("FAIL midrst_mem k=%0d got %h want 0", k, rdv);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int rc, sc, l, per; logic [31:0] rdv, ed, v; logic ev, ds, ee, erd;
        for (int k = 0; k < 2; k++) begin
            l = lat_of(k); per = l + 1;
            for (int j = 0; j < 3; j++) begin
                v = $urandom;
                model_apply(k, 1'b0, 1'b1, 32'(j * 4), v, ed, ee);
                run_access(k, 1'b0, 1'b1, 32'(j * 4), v, 1'b0, 32'h0, 32'h0, rc, sc, rdv, ev, ds);
            end
            @(negedge clk);
            mrd[k] = 1'b1; addr[k] = 32'h0;
            for (int c = 0; c < 3 * per; c++) begin
                #1;
                erd = ((c % per) == l);
                n_checks++;
                if (rdy[k] !== erd) $display("FAIL b2b_ready k=%0d c=%0d got %b want %b", k, c, rdy[k], erd);
                else n_pass++;
                n_checks++;
                if (stall[k] !== !erd) $display("FAIL b2b_stall k=%0d c=%0d got %b want %b", k, c, stall[k], !erd);
                else n_pass++;
                if (erd) begin
                    model_apply(k, 1'b1, 1'b0, 32'((c / per) * 4), 32'h0, ed, ee);
                    n_checks++;
                    if (rdata[k] !== ed) $display("FAIL b2b_rdata k=%0d c=%0d got %h want %h", k, c, rdata[k], ed);
                    else n_pass++;
                    addr[k] = 32'((c / per + 1) * 4);
                end
                if (c == 3 * per - 1) mrd[k] = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random();
        int k, r, op, rc, sc; logic [31:0] a, wd, rdv, ed; logic rd, wr, keep, ev, ds, ee;
        for (int i = 0; i < 72; i++) begin
            if (i < 24) begin
                k = i / 8; a = 32'((i % 8) * 4); rd = 1'b0; wr = 1'b1; keep = 1'b0;
            end else begin
                k = $urandom_range(0, 2);
                r = $urandom_range(0, 9);
                if (r < 8) a = 32'(r * 4);
                else if (r == 8) a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
                else a = 32'h400 + 32'($urandom_range(0, 255) * 4);
                op = $urandom_range(0, 4);
                rd = (op < 2) || (op == 4);
                wr = (op >= 2);
                keep = 1'($urandom_range(0, 1));
            end
            wd = $urandom;
            model_apply(k, rd, wr, a, wd, ed, ee);
            run_access(k, rd, wr, a, wd, keep, $urandom, $urandom, rc, sc, rdv, ev, ds);
            n_checks++;
            if (rc != lat_of(k) || sc != lat_of(k) || ds !== 1'b0)
                $display("FAIL rnd_timing i=%0d k=%0d got ready@%0d stall=%0d done_stall=%b want %0d/%0d/0",
                         i, k, rc, sc, ds, lat_of(k), lat_of(k));
            else n_pass++;
            n_checks++;
            if (ev !== ee || rdv !== ed)
                $display("FAIL rnd_result i=%0d k=%0d a=%h got err=%b data=%h want err=%b data=%h",
                         i, k, a, ev, rdv, ee, ed);
            else n_pass++;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; mrd[k] = 1'b0; mwr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            last_m[k] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_latency_sweep();
        test_errors();
        test_input_hold();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, the number of 32-bit words of storage.
REQ-002 SHALL have parameter LATENCY, default 2, the number of cycles from request accept to Ready; legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port MemRead  input  1  read request from the MEM stage.
REQ-006 SHALL have port MemWrite  input  1  write request from the MEM stage.
REQ-007 SHALL have port Address  input  32  byte address; word index is Address[31:2].
REQ-008 SHALL have port WriteData  input  32  store data.
REQ-009 SHALL have port ReadData  output  32  load data, valid while Ready=1, held otherwise.
REQ-010 SHALL have port Ready  output  1  one-cycle pulse marking request completion.
REQ-011 SHALL have port Stall  output  1  pipeline hold request while an access is outstanding.
REQ-012 SHALL have port Error  output  1  one-cycle pulse, coincident with Ready, marking a rejected access.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE; reset state is IDLE.
REQ-014 In IDLE, with MemRead|MemWrite=1, the block SHALL accept the request.
- Latch Address, WriteData, request type and error status.
- Load the latency counter with LATENCY-1.
- Go to BUSY, or to DONE directly when LATENCY=1.
REQ-015 In BUSY, the block SHALL decrement the counter each cycle and go to DONE on the cycle the counter reads 0.
REQ-016 In DONE, the block SHALL assert Ready=1, then go to IDLE on the next edge with no new accept in the DONE cycle itself.
REQ-017 Ready SHALL rise exactly LATENCY cycles after the accept edge.
REQ-018 Stall SHALL be combinational: 1 in IDLE while a request is present, 1 in BUSY, 0 in DONE and in idle IDLE.
REQ-019 A valid read SHALL present mem[latched index] on ReadData in the DONE cycle, registered on the transition edge into DONE.
REQ-020 A valid write SHALL commit mem[latched index]=latched WriteData on the edge leaving DONE; ReadData SHALL be unchanged by writes.
REQ-021 An error access SHALL be any of:
- MemRead and MemWrite both 1 at accept;
- latched Address[1:0]!=0;
- latched Address[31:2] >= DEPTH.
REQ-022 An error access SHALL follow identical FSM timing and assert Error=1 with Ready. It SHALL NOT write memory and SHALL drive ReadData=0.
REQ-023 Input changes on MemRead, MemWrite, Address or WriteData after accept SHALL be ignored until return to IDLE.
REQ-024 Back-to-back requests SHALL be accepted in the IDLE cycle immediately after DONE; minimum request spacing is LATENCY+1 cycles.
REQ-025 Memory contents SHALL be uninitialised by the block; a bench or synthesis initialisation file is the only initialisation source.

Reset
REQ-026 On reset=1, the block SHALL set state=IDLE, counter=0, Ready=0, Error=0 and ReadData=32'h0; Stall SHALL evaluate to 0 when no request is present.
REQ-027 Reset SHALL have priority over any request on the same edge; no accept SHALL occur on a reset edge.
REQ-028 Reset during BUSY or DONE SHALL abort the access: a pending write SHALL NOT commit, and no Ready or Error pulse SHALL follow.
REQ-029 Reset SHALL NOT clear memory contents.

Verification
REQ-030 Write then read: write Address=0x10, WriteData=0xDEADBEEF with LATENCY=2, then read 0x10.
- Stall=1 for 2 cycles per access.
- Ready pulses at accept+2.
- The read returns 0xDEADBEEF.
REQ-031 Latency sweep: with LATENCY=1 and LATENCY=15, a read of a preloaded word at 0x0 SHALL produce Ready exactly 1 and 15 cycles after accept, with Stall high exactly as long.
REQ-032 Error cases, each producing Error=Ready=1, ReadData=0, and memory unchanged on a follow-up read:
- Address=0x12;
- Address=0x400 with DEPTH=256;
- MemRead=MemWrite=1.
REQ-033 Reset mid-write: accept a write of 0x12345678 to 0x20 (prior value 0x0), then assert reset in BUSY.
- No Ready pulse follows.
- A subsequent read of 0x20 returns 0x0.
REQ-034 Input hold: change Address from 0x8 to 0xC one cycle after a read accept; the data returned SHALL be from 0x8.
REQ-035 Back-to-back: hold MemRead=1 continuously across Address 0x0, 0x4, 0x8; Ready SHALL pulse every LATENCY+1 cycles, and Stall SHALL drop only in each DONE cycle.
